// File: rtl/memory_arbiter.sv
// memory_arbiter: two-client arbiter and sequencer for the shared buffer memory.
// Write and read channels are arbitrated independently (round-robin by default),
// the memory strobes are registered, and read data is steered back to the
// issuing client through a RD_LATENCY-deep tag pipeline.
// Build option: define MEMARB_FIXED_PRIO_EN for fixed priority (client 0 wins
// contention on both channels); the round-robin pointers are then removed.
module memory_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 1    // legal range 1..4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_enable,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              mem_rd_enable,
    input  logic [DATA_W-1:0] mem_rd_data
);

`ifdef MEMARB_FIXED_PRIO_EN
    // Fixed priority: a lone candidate wins, otherwise client 0 wins.
    function automatic logic [1:0] arbitrate(input logic [1:0] cand);
        logic [1:0] pick;
        pick = cand;
        if (cand == 2'b11) begin
            pick = 2'b01;
        end
        return pick;
    endfunction
`else
    // Round-robin: a lone candidate wins, otherwise the client not granted last.
    // 'last' is the id of the client granted last on this channel.
    function automatic logic [1:0] arbitrate(input logic [1:0] cand, input logic last);
        logic [1:0] pick;
        pick = cand;
        if (cand == 2'b11) begin
            pick = last ? 2'b01 : 2'b10;
        end
        return pick;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Request decode and arbitration
    // ------------------------------------------------------------------
    logic [1:0]        wr_cand;
    logic [1:0]        rd_cand;
    logic [1:0]        wr_pick;
    logic [1:0]        rd_pick;
    logic [ADDR_W-1:0] wr_addr_sel;
    logic [DATA_W-1:0] wr_data_sel;
    logic [ADDR_W-1:0] rd_addr_sel;
    logic              hazard;
    logic [1:0]        wr_gnt;
    logic [1:0]        rd_gnt;

    assign wr_cand = req & we;
    assign rd_cand = req & ~we;

`ifdef MEMARB_FIXED_PRIO_EN
    assign wr_pick = arbitrate(wr_cand);
    assign rd_pick = arbitrate(rd_cand);
`else
    logic wr_last_q;
    logic wr_last_d;
    logic rd_last_q;
    logic rd_last_d;

    assign wr_pick = arbitrate(wr_cand, wr_last_q);
    assign rd_pick = arbitrate(rd_cand, rd_last_q);
`endif

    // The two winners are always different clients, since each client
    // requests exactly one direction at a time.
    assign wr_addr_sel = wr_pick[1] ? addr1  : addr0;
    assign wr_data_sel = wr_pick[1] ? wdata1 : wdata0;
    assign rd_addr_sel = rd_pick[1] ? addr1  : addr0;

    // A read to the address being written this cycle waits one cycle so it
    // observes the new data instead of racing the write at the memory.
    assign hazard = (|wr_pick) && (|rd_pick) && (wr_addr_sel == rd_addr_sel);

    // Grants are forced low during reset so every output reads 0 while rst is high.
    assign wr_gnt = rst ? 2'b00 : wr_pick;
    assign rd_gnt = (rst || hazard) ? 2'b00 : rd_pick;
    assign gnt    = wr_gnt | rd_gnt;

    // ------------------------------------------------------------------
    // Issue registers (IMemory strobes)
    // ------------------------------------------------------------------
    logic              mem_wr_enable_q, mem_wr_enable_d;
    logic [ADDR_W-1:0] mem_wr_addr_q,   mem_wr_addr_d;
    logic [DATA_W-1:0] mem_wr_data_q,   mem_wr_data_d;
    logic              mem_rd_enable_q, mem_rd_enable_d;
    logic [ADDR_W-1:0] mem_rd_addr_q,   mem_rd_addr_d;
    logic              mem_rd_id_q,     mem_rd_id_d;

    // Next-state for the strobes: one-cycle pulse after a grant, address and
    // data latched from the winner and held between accesses.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        mem_wr_enable_d = |wr_gnt;
        mem_wr_addr_d   = mem_wr_addr_q;
        mem_wr_data_d   = mem_wr_data_q;
        mem_rd_enable_d = |rd_gnt;
        mem_rd_addr_d   = mem_rd_addr_q;
        mem_rd_id_d     = mem_rd_id_q;
        if (|wr_gnt) begin
            mem_wr_addr_d = wr_addr_sel;
            mem_wr_data_d = wr_data_sel;
        end
        if (|rd_gnt) begin
            mem_rd_addr_d = rd_addr_sel;
            mem_rd_id_d   = rd_gnt[1];
        end
    end

    // Strobe, address and data registers for both memory channels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wr_enable_q <= 1'b0;
            mem_wr_addr_q   <= '0;
            mem_wr_data_q   <= '0;
            mem_rd_enable_q <= 1'b0;
            mem_rd_addr_q   <= '0;
            mem_rd_id_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            mem_wr_enable_q <= mem_wr_enable_d;
            mem_wr_addr_q   <= mem_wr_addr_d;
            mem_wr_data_q   <= mem_wr_data_d;
            mem_rd_enable_q <= mem_rd_enable_d;
            mem_rd_addr_q   <= mem_rd_addr_d;
            mem_rd_id_q     <= mem_rd_id_d;
        end
    end

    assign mem_wr_enable = mem_wr_enable_q;
    assign mem_wr_addr   = mem_wr_addr_q;
    assign mem_wr_data   = mem_wr_data_q;
    assign mem_rd_enable = mem_rd_enable_q;
    assign mem_rd_addr   = mem_rd_addr_q;

`ifndef MEMARB_FIXED_PRIO_EN
    // ------------------------------------------------------------------
    // Round-robin pointers: move only when their own channel grants.
    // ------------------------------------------------------------------
    // Pointer next-state: remember which client just won.
    always_comb begin
        wr_last_d = wr_last_q;
        rd_last_d = rd_last_q;
        if (|wr_gnt) begin
            wr_last_d = wr_gnt[1];
        end
        if (|rd_gnt) begin
            rd_last_d = rd_gnt[1];
        end
    end

    // Pointer registers; reset to "client 1 was last" so client 0 wins next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_last_q <= 1'b1;
            rd_last_q <= 1'b1;
        end else begin
            wr_last_q <= wr_last_d;
            rd_last_q <= rd_last_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read tag pipeline: {valid, client id}, loaded while mem_rd_enable is
    // high, tail lines up with the memory's read data.
    // ------------------------------------------------------------------
    logic [RD_LATENCY-1:0] tag_valid_q, tag_valid_d;
    logic [RD_LATENCY-1:0] tag_id_q,    tag_id_d;
    logic                  tail_valid;
    logic                  tail_id;

    // Shift the tag pipeline by one slot every cycle.
    always_comb begin
        tag_valid_d    = tag_valid_q;
        tag_id_d       = tag_id_q;
        tag_valid_d[0] = mem_rd_enable_q;
        tag_id_d[0]    = mem_rd_id_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_id_d[i]    = tag_id_q[i-1];
        end
    end

    // Tag pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this storage is reset (unlike a data memory) because its
            // valid bits must drop so in-flight reads never return after reset.
            tag_valid_q <= '0;
            tag_id_q    <= '0;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_id_q    <= tag_id_d;
        end
    end

    assign tail_valid = tag_valid_q[RD_LATENCY-1];
    assign tail_id    = tag_id_q[RD_LATENCY-1];

    // Steer read data to the owner of the tail tag; drive zeros otherwise.
    always_comb begin
        rvalid = 2'b00;
        rdata  = '0;
        if (tail_valid) begin
            rvalid = tail_id ? 2'b10 : 2'b01;
            rdata  = mem_rd_data;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed test of memory_arbiter with a behavioural
// reference model checked every cycle, plus hand-computed literal checks.
module tb_memory_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int LAT    = 1;
`ifdef MEMARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic [1:0]        gnt;
    logic [1:0]        rvalid;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_enable;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_enable;
    logic [DATA_W-1:0] mem_rd_data;

    memory_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_enable(mem_wr_enable), .mem_rd_addr(mem_rd_addr),
        .mem_rd_enable(mem_rd_enable), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory behind the IMemory bus ----------------
    logic [DATA_W-1:0] tb_mem [256];
    logic [DATA_W-1:0] rd_pipe [LAT];
    always @(posedge clk) begin
        if (mem_wr_enable) tb_mem[mem_wr_addr] <= mem_wr_data;
        rd_pipe[0] <= tb_mem[mem_rd_addr];
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rd_data = rd_pipe[LAT-1];

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int                due;
        int                client;
        logic [DATA_W-1:0] data;
    } rd_exp_t;

    rd_exp_t           rd_q[$];
    logic [DATA_W-1:0] ref_mem [256];
    int                m_wr_last = 1;   // client granted last on each channel
    int                m_rd_last = 1;
    bit                m_wen = 0, m_ren = 0;
    logic [ADDR_W-1:0] m_waddr, m_raddr;
    logic [DATA_W-1:0] m_wdata;

    // Spec rule: lone candidate wins; with two, fixed -> client 0,
    // round-robin -> whichever client was not granted last.
    function automatic logic [1:0] model_pick(input logic [1:0] cand, input int last);
        if (cand != 2'b11) return cand;
        if (FIXED_PRIO) return 2'b01;
        return (last == 0) ? 2'b10 : 2'b01;
    endfunction

    always @(negedge clk) begin
        logic [1:0]        wg, rg;
        logic [ADDR_W-1:0] wa, ra;
        logic [DATA_W-1:0] wd;
        rd_exp_t           e;
        if (rst) begin
            check("rst_gnt", {30'd0, gnt}, 32'd0);
            check("rst_rvalid", {30'd0, rvalid}, 32'd0);
            check("rst_rdata", {16'd0, rdata}, 32'd0);
            check("rst_mem", {mem_wr_enable, mem_rd_enable, mem_wr_addr, mem_rd_addr, mem_wr_data},
                  32'd0);
            rd_q.delete();
            m_wr_last = 1;
            m_rd_last = 1;
            m_wen = 0;
            m_ren = 0;
        end else begin
            wg = model_pick(req & we, m_wr_last);
            rg = model_pick(req & ~we, m_rd_last);
            wa = (wg == 2'b10) ? addr1 : addr0;
            wd = (wg == 2'b10) ? wdata1 : wdata0;
            ra = (rg == 2'b10) ? addr1 : addr0;
            if (wg != 0 && rg != 0 && wa == ra) rg = 2'b00;

            check("gnt", {30'd0, gnt}, {30'd0, wg | rg});
            check("mem_wr_enable", {31'd0, mem_wr_enable}, {31'd0, m_wen});
            if (m_wen) check("mem_wr_addr_data", {mem_wr_addr, mem_wr_data}, {8'd0, m_waddr, m_wdata});
            check("mem_rd_enable", {31'd0, mem_rd_enable}, {31'd0, m_ren});
            if (m_ren) check("mem_rd_addr", {24'd0, mem_rd_addr}, {24'd0, m_raddr});
            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                e = rd_q.pop_front();
                check("rvalid", {30'd0, rvalid}, (e.client == 1) ? 32'd2 : 32'd1);
                check("rdata", {16'd0, rdata}, {16'd0, e.data});
            end else begin
                check("rvalid_idle", {30'd0, rvalid}, 32'd0);
                check("rdata_idle", {16'd0, rdata}, 32'd0);
            end

            m_wen = (wg != 0);
            m_ren = (rg != 0);
            if (rg != 0) begin
                m_raddr  = ra;
                e.due    = cyc + 1 + LAT;
                e.client = (rg == 2'b10) ? 1 : 0;
                e.data   = ref_mem[ra];
                rd_q.push_back(e);
                m_rd_last = e.client;
            end
            if (wg != 0) begin
                m_waddr = wa;
                m_wdata = wd;
                ref_mem[wa] = wd;
                m_wr_last = (wg == 2'b10) ? 1 : 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] w,
                         input logic [7:0] a0, input logic [7:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1);
        req = r; we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    endtask

    // Waits (bounded) for the next rvalid pulse; at = -1 if none arrives.
    task automatic wait_rvalid(output int at);
        at = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rvalid != 2'b00) begin
                at = cyc;
                break;
            end
        end
    endtask

    logic [1:0] rr_seq [4];
    int g_cyc, r_cyc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = '0;
            ref_mem[i] = '0;
        end
        for (int k = 0; k < LAT; k++) rd_pipe[k] = '0;
        if (FIXED_PRIO) begin
            rr_seq[0] = 2'b01; rr_seq[1] = 2'b01; rr_seq[2] = 2'b01; rr_seq[3] = 2'b01;
        end else begin
            // Client 0 won the last write (test 1), so client 1 goes first.
            rr_seq[0] = 2'b10; rr_seq[1] = 2'b01; rr_seq[2] = 2'b10; rr_seq[3] = 2'b01;
        end
        rst = 1'b1;
        drive(2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000);
        repeat (3) next_cycle();
        rst = 1'b0;
        next_cycle();

        // 1: single write from client 0
        drive(2'b01, 2'b01, 8'h02, 8'h00, 16'hABCD, 16'h0000);
        @(negedge clk);
        check("t1_gnt", {30'd0, gnt}, 32'd1);
        next_cycle();
        drive(2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000);
        @(negedge clk);
        check("t1_strobe", {7'd0, mem_wr_enable, mem_wr_addr, mem_wr_data}, {7'd0, 1'b1, 8'h02, 16'hABCD});
        repeat (9) next_cycle();

        // 2: client 1 reads back the written word
        drive(2'b10, 2'b00, 8'h00, 8'h02, 16'h0000, 16'h0000);
        @(negedge clk);
        check("t2_gnt", {30'd0, gnt}, 32'd2);
        g_cyc = cyc;
        next_cycle();
        drive(2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000);
        wait_rvalid(r_cyc);
        check("t2_rvalid", {30'd0, rvalid}, 32'd2);
        check("t2_latency", r_cyc - g_cyc, 1 + LAT);
        check("t2_rdata", {16'd0, rdata}, 32'h0000ABCD);
        next_cycle();

        // 3: both clients write continuously
        drive(2'b11, 2'b11, 8'h10, 8'h20, 16'h1010, 16'h2020);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_gnt_seq", {30'd0, gnt}, {30'd0, rr_seq[i]});
            next_cycle();
        end
        drive(2'b10, 2'b10, 8'h10, 8'h20, 16'h1010, 16'h2020);
        @(negedge clk);
        check("t3_gnt_c1_only", {30'd0, gnt}, 32'd2);
        next_cycle();
        drive(2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000);
        next_cycle();

        // 4: same-address write/read in one cycle -> read deferred
        drive(2'b11, 2'b01, 8'h05, 8'h05, 16'h1234, 16'h0000);
        @(negedge clk);
        check("t4_gnt_write_only", {30'd0, gnt}, 32'd1);
        next_cycle();
        drive(2'b10, 2'b00, 8'h05, 8'h05, 16'h0000, 16'h0000);
        @(negedge clk);
        check("t4_gnt_deferred_read", {30'd0, gnt}, 32'd2);
        g_cyc = cyc;
        next_cycle();
        drive(2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000);
        wait_rvalid(r_cyc);
        check("t4_rvalid", {30'd0, rvalid}, 32'd2);
        check("t4_latency", r_cyc - g_cyc, 1 + LAT);
        check("t4_rdata", {16'd0, rdata}, 32'h00001234);
        repeat (2) next_cycle();

        // 5: write and read to different addresses in one cycle
        drive(2'b11, 2'b01, 8'h05, 8'h06, 16'h5555, 16'h0000);
        @(negedge clk);
        check("t5_gnt_both", {30'd0, gnt}, 32'd3);
        next_cycle();
        drive(2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000);
        @(negedge clk);
        check("t5_strobes", {14'd0, mem_wr_enable, mem_rd_enable, mem_wr_addr, mem_rd_addr},
              {14'd0, 1'b1, 1'b1, 8'h05, 8'h06});
        repeat (4) next_cycle();

        // 6: reset while a read is in flight
        drive(2'b10, 2'b00, 8'h00, 8'h02, 16'h0000, 16'h0000);
        @(negedge clk);
        check("t6_gnt", {30'd0, gnt}, 32'd2);
        next_cycle();
        drive(2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000);
        repeat (LAT - 1) next_cycle();
        rst = 1'b1;
        drive(2'b11, 2'b11, 8'h30, 8'h40, 16'h3030, 16'h4040);
        @(negedge clk);
        check("t6_rst_gnt", {30'd0, gnt}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("t6_no_rvalid", {30'd0, rvalid}, 32'd0);
        repeat (2) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("t6_first_gnt", {30'd0, gnt}, 32'd1);
        next_cycle();
        drive(2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000);
        repeat (6) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
